// File: rtl/rr_grant_controller.sv
// Round-robin arbiter with hold-until-release grants and an optional hold timeout.
// Publishes the owner as a binary index and as a registered one-hot grant.
module rr_grant_controller #(
  parameter int WIDTH    = 2,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [(1<<WIDTH)-1:0]   req,
  output logic [(1<<WIDTH)-1:0]   grant,
  output logic [WIDTH-1:0]        grant_idx,
  output logic                    grant_valid,
  output logic                    preempt
);

  localparam int N = 1 << WIDTH;
  localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_I);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    ptr_reg, ptr_next;
  logic [HOLD_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]    idx_reg, idx_next;
  logic                valid_reg, valid_next;
  logic                preempt_reg, preempt_next;
  logic [N-1:0]        grant_reg, grant_next;

  // Requests rotated so that bit 0 corresponds to the pointer position.
  logic [N-1:0]        rot_req;
  logic [WIDTH-1:0]    pick_off;
  logic [WIDTH-1:0]    pick_idx;
  logic                pick_any;
  logic                owner_req;
  logic                timeout;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [WIDTH-1:0] pos;
    assign pos         = ptr_reg + WIDTH'(gi);
    assign rot_req[gi] = req[pos];
  end

  always_comb begin
    pick_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) pick_off = WIDTH'(i);
    end
  end

  assign pick_idx  = ptr_reg + pick_off;
  assign pick_any  = |req;
  assign owner_req = req[idx_reg];
  assign timeout   = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    preempt_next = 1'b0;

    if (state_reg == IDLE || !owner_req) begin
      // Fresh pick from idle, or back-to-back handover on release.
      if (enable && pick_any) begin
        state_next = BUSY;
        idx_next   = pick_idx;
        valid_next = 1'b1;
        ptr_next   = pick_idx + WIDTH'(1);
        cnt_next   = '0;
      end else begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    end else if (timeout) begin
      preempt_next = 1'b1;
      if (enable) begin
        idx_next   = pick_idx;
        valid_next = 1'b1;
        ptr_next   = pick_idx + WIDTH'(1);
        cnt_next   = '0;
      end else begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    end else if (cnt_reg != '1) begin
      cnt_next = cnt_reg + HOLD_W'(1);
    end

    grant_next = '0;
    if (valid_next) grant_next[idx_next] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
      grant_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      preempt_reg <= preempt_next;
      grant_reg   <= grant_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;
  assign preempt     = preempt_reg;

endmodule

// File: tb/tb_rr_grant_controller.sv
// Scoreboard bench for rr_grant_controller: a behavioural model queues expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_rr_grant_controller;

  localparam int WIDTH    = 2;
  localparam int HOLD_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int N        = 1 << WIDTH;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] grant_idx;
  logic             grant_valid;
  logic             preempt;

  always #5 clock = ~clock;

  rr_grant_controller #(
    .WIDTH    (WIDTH),
    .HOLD_W   (HOLD_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  typedef struct packed {
    logic [N-1:0]     g;
    logic [WIDTH-1:0] idx;
    logic             v;
    logic             p;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model state
  bit m_busy;
  int m_ptr, m_cnt, m_idx;
  bit m_valid, m_pre;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_busy  = 1;
    m_idx   = w;
    m_valid = 1;
    m_ptr   = (w + 1) % N;
    m_cnt   = 0;
  endtask

  task automatic go_idle();
    m_busy  = 0;
    m_valid = 0;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [N-1:0] r);
    int w;
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_idx = 0; m_valid = 0; m_pre = 0;
    end else begin
      w = pick(r, m_ptr);
      m_pre = 0;
      if (!m_busy || !r[m_idx]) begin
        if (en && w >= 0) give(w);
        else go_idle();
      end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1) begin
        m_pre = 1;
        if (en) give(w);
        else go_idle();
      end else if (m_cnt < (1 << HOLD_W) - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [N-1:0] r);
    exp_t e;
    reset_n = rst;
    enable  = en;
    req     = r;
    model_step(rst, en, r);
    e.g   = '0;
    for (int j = 0; j < N; j++) if (m_valid && j == m_idx) e.g[j] = 1'b1;
    e.idx = m_idx[WIDTH-1:0];
    e.v   = m_valid;
    e.p   = m_pre;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    $display("[TB] t=%0t rst_n=%b en=%b req=%b -> grant=%b idx=%0d valid=%b preempt=%b",
             $time, rst, en, r, grant, grant_idx, grant_valid, preempt);
    check_eq("grant", 32'(grant), 32'(e.g));
    check_eq("grant_idx", 32'(grant_idx), 32'(e.idx));
    check_eq("grant_valid", 32'(grant_valid), 32'(e.v));
    check_eq("preempt", 32'(preempt), 32'(e.p));
    check_eq("onehot", 32'($countones(grant) <= 1), 32'd1);
    check_eq("valid_or", 32'(grant_valid), 32'(|grant));
  endtask

  int rot_exp [17] = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4, 8, 8, 8, 8, 1};
  int pre_cnt;

  initial begin
    #1;
    // Reset with all requesting
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'b1111);
    check_eq("reset_grant", 32'(grant), 32'h0);

    // Rotation under contention
    pre_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b1, 4'b1111);
      check_eq("rot_seq", 32'(grant), 32'(rot_exp[i]));
      if (preempt) pre_cnt++;
    end
    check_eq("rot_preempts", 32'(pre_cnt), 32'd4);

    // Release and back-to-back handover
    cycle(1'b1, 1'b1, 4'b0011);
    cycle(1'b1, 1'b1, 4'b0010);
    check_eq("back2back", 32'(grant), 32'b0010);
    cycle(1'b1, 1'b1, 4'b0000);
    check_eq("release_idle", 32'(grant_valid), 32'd0);

    // Wrap and pointer retained across IDLE
    cycle(1'b1, 1'b1, 4'b0100);
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b1, 1'b1, 4'b1001);
    check_eq("wrap_pick3", 32'(grant), 32'b1000);
    cycle(1'b1, 1'b1, 4'b0001);
    check_eq("wrap_then0", 32'(grant), 32'b0001);
    cycle(1'b1, 1'b1, 4'b0000);

    // Lone requester repeatedly times out but keeps the grant
    pre_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 4'b0010);
      check_eq("lone_grant", 32'(grant), 32'b0010);
      if (preempt) pre_cnt++;
    end
    check_eq("lone_preempts", 32'(pre_cnt), 32'd2);

    // enable low blocks handover; reset mid-grant
    cycle(1'b1, 1'b0, 4'b0110);
    cycle(1'b1, 1'b0, 4'b0100);
    check_eq("en_low_idle", 32'(grant), 32'h0);
    cycle(1'b1, 1'b1, 4'b0100);
    check_eq("en_high_grant", 32'(grant), 32'b0100);
    cycle(1'b0, 1'b1, 4'b0110);
    check_eq("reset_midgrant", 32'(grant), 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) != 0),
            N'($urandom_range(0, N * 2 - 1) & $urandom_range(0, N - 1) | (($urandom_range(0, 3) == 0) ? 0 : N'($urandom))));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
